// File: rtl/pc_fetch_unit.sv
// Program counter and next-PC stage feeding the instruction memory (word addressed).
// Handles redirects, stall, halt/resume, out-of-range fetch trapping and a retire counter.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter int unsigned IM_DEPTH = 32
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        STALL,
  input  logic        BRANCH_TAKEN,
  input  logic [15:0] BR_IMM,
  input  logic        JUMP,
  input  logic [25:0] JUMP_TARGET,
  input  logic        JR,
  input  logic [31:0] JR_ADDR,
  input  logic        HALT_REQ,
  input  logic        RESUME,
  output logic [31:0] PC,
  output logic [31:0] PC_PLUS1,
  output logic        HALTED,
  output logic        FAULT,
  output logic [31:0] RETIRED
);

  localparam logic [31:0] LP_DEPTH = 32'(IM_DEPTH);

  typedef enum logic [1:0] {
    S_RUN,
    S_HALT,
    S_FAULT
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_retired;
  logic        r_halted;
  logic        r_fault;

  logic [31:0] w_pc_plus1;
  logic [31:0] w_br_target;
  logic [31:0] w_next;
  logic        w_next_oob;
  logic        w_seq_oob;

  assign w_pc_plus1  = r_pc + 32'd1;
  assign w_br_target = w_pc_plus1 + {{16{BR_IMM[15]}}, BR_IMM};

  always_comb begin
    w_next = w_pc_plus1;
    if (JR)                w_next = JR_ADDR;
    else if (JUMP)         w_next = {r_pc[31:26], JUMP_TARGET};
    else if (BRANCH_TAKEN) w_next = w_br_target;
  end

  // Unsigned compare: a branch that wraps below zero lands here as a huge address.
  assign w_next_oob = (w_next >= LP_DEPTH);
  assign w_seq_oob  = (w_pc_plus1 >= LP_DEPTH);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= S_RUN;
      r_pc      <= RESET_PC;
      r_retired <= '0;
      r_halted  <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (!STALL) begin
            r_retired <= r_retired + 32'd1;
            if (HALT_REQ) begin
              r_state  <= S_HALT;
              r_halted <= 1'b1;
            end else if (w_next_oob) begin
              r_state <= S_FAULT;
              r_fault <= 1'b1;
            end else begin
              r_pc <= w_next;
            end
          end
        end
        S_HALT: begin
          if (RESUME) begin
            r_halted <= 1'b0;
            if (w_seq_oob) begin
              r_state <= S_FAULT;
              r_fault <= 1'b1;
            end else begin
              r_state <= S_RUN;
              r_pc    <= w_pc_plus1;
            end
          end
        end
        S_FAULT: begin
          r_state <= S_FAULT;
        end
        default: begin
          r_state  <= S_FAULT;
          r_halted <= 1'b0;
          r_fault  <= 1'b1;
        end
      endcase
    end
  end

  assign PC       = r_pc;
  assign PC_PLUS1 = w_pc_plus1;
  assign HALTED   = r_halted;
  assign FAULT    = r_fault;
  assign RETIRED  = r_retired;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with hand-computed expected values.
module tb_pc_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        STALL = 1'b0;
  logic        BRANCH_TAKEN = 1'b0;
  logic [15:0] BR_IMM = '0;
  logic        JUMP = 1'b0;
  logic [25:0] JUMP_TARGET = '0;
  logic        JR = 1'b0;
  logic [31:0] JR_ADDR = '0;
  logic        HALT_REQ = 1'b0;
  logic        RESUME = 1'b0;
  logic [31:0] PC;
  logic [31:0] PC_PLUS1;
  logic        HALTED;
  logic        FAULT;
  logic [31:0] RETIRED;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  pc_fetch_unit #(.RESET_PC(32'd0), .IM_DEPTH(32)) dut (
    .CLK(CLK), .RST(RST), .STALL(STALL), .BRANCH_TAKEN(BRANCH_TAKEN),
    .BR_IMM(BR_IMM), .JUMP(JUMP), .JUMP_TARGET(JUMP_TARGET), .JR(JR),
    .JR_ADDR(JR_ADDR), .HALT_REQ(HALT_REQ), .RESUME(RESUME), .PC(PC),
    .PC_PLUS1(PC_PLUS1), .HALTED(HALTED), .FAULT(FAULT), .RETIRED(RETIRED)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] pc, input logic [31:0] ret,
                         input logic h, input logic f);
    chk({tag, ".pc"}, PC, pc);
    chk({tag, ".pc1"}, PC_PLUS1, pc + 32'd1);
    chk({tag, ".ret"}, RETIRED, ret);
    chk({tag, ".halted"}, {31'd0, HALTED}, {31'd0, h});
    chk({tag, ".fault"}, {31'd0, FAULT}, {31'd0, f});
  endtask

  initial begin
    // Reset and sequential fetch
    #2; RST = 1'b1; step(); RST = 1'b0;
    chk_all("reset", 32'd0, 32'd0, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk_all("seq", 32'(i), 32'(i), 1'b0, 1'b0);
    end
    for (int i = 5; i <= 10; i++) step();
    chk_all("seq10", 32'd10, 32'd10, 1'b0, 1'b0);

    // Redirect priority
    BRANCH_TAKEN = 1'b1; BR_IMM = 16'hFFFA; step();
    chk_all("branch", 32'd5, 32'd11, 1'b0, 1'b0);
    JUMP = 1'b1; JUMP_TARGET = 26'd20; step();
    chk_all("jump_over_br", 32'd20, 32'd12, 1'b0, 1'b0);
    JR = 1'b1; JR_ADDR = 32'd3; step();
    chk_all("jr_over_jump", 32'd3, 32'd13, 1'b0, 1'b0);
    JR = 1'b0; JUMP = 1'b0; BRANCH_TAKEN = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk_all("seq7", 32'd7, 32'd17, 1'b0, 1'b0);

    // Stall ignores redirects
    STALL = 1'b1; BRANCH_TAKEN = 1'b1; BR_IMM = 16'd5;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("stall", 32'd7, 32'd17, 1'b0, 1'b0);
    end
    STALL = 1'b0; BRANCH_TAKEN = 1'b0; step();
    chk_all("unstall", 32'd8, 32'd18, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step();
    chk_all("seq12", 32'd12, 32'd22, 1'b0, 1'b0);

    // Halt / resume
    HALT_REQ = 1'b1; JUMP = 1'b1; JUMP_TARGET = 26'd5; step(); HALT_REQ = 1'b0;
    chk_all("halt", 32'd12, 32'd23, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk_all("halt_hold", 32'd12, 32'd23, 1'b1, 1'b0);
    end
    JUMP = 1'b0; RESUME = 1'b1; step(); RESUME = 1'b0;
    chk_all("resume", 32'd13, 32'd23, 1'b0, 1'b0);

    // Fault at top of IM, then stuck until reset
    JR = 1'b1; JR_ADDR = 32'd31; step(); JR = 1'b0;
    chk_all("jr31", 32'd31, 32'd24, 1'b0, 1'b0);
    step();
    chk_all("seq_fault", 32'd31, 32'd25, 1'b0, 1'b1);
    JR = 1'b1; JR_ADDR = 32'd0; step(); JR = 1'b0;
    chk_all("fault_hold", 32'd31, 32'd25, 1'b0, 1'b1);
    RST = 1'b1; step(); RST = 1'b0;
    chk_all("fault_rst", 32'd0, 32'd0, 1'b0, 1'b0);

    // Branch wrapping below zero faults
    BRANCH_TAKEN = 1'b1; BR_IMM = 16'hFFFE; step(); BRANCH_TAKEN = 1'b0;
    chk_all("br_wrap", 32'd0, 32'd1, 1'b0, 1'b1);
    RST = 1'b1; step(); RST = 1'b0;

    // JR exactly at IM_DEPTH faults
    JR = 1'b1; JR_ADDR = 32'd32; step(); JR = 1'b0;
    chk_all("jr32", 32'd0, 32'd1, 1'b0, 1'b1);
    RST = 1'b1; step(); RST = 1'b0;

    // Resume from PC=31 faults without retiring
    JR = 1'b1; JR_ADDR = 32'd31; step(); JR = 1'b0;
    HALT_REQ = 1'b1; step(); HALT_REQ = 1'b0;
    chk_all("halt31", 32'd31, 32'd2, 1'b1, 1'b0);
    RESUME = 1'b1; step(); RESUME = 1'b0;
    chk_all("resume_fault", 32'd31, 32'd2, 1'b0, 1'b1);
    RST = 1'b1; step(); RST = 1'b0;

    // Reset beats resume while halted
    step(); step();
    chk_all("seq2", 32'd2, 32'd2, 1'b0, 1'b0);
    HALT_REQ = 1'b1; step(); HALT_REQ = 1'b0;
    chk_all("halt2", 32'd2, 32'd3, 1'b1, 1'b0);
    RST = 1'b1; RESUME = 1'b1; step(); RST = 1'b0; RESUME = 1'b0;
    chk_all("rst_vs_resume", 32'd0, 32'd0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
